// File: rtl/abot_hbridge_ctrl.sv
// abot_hbridge_ctrl
// Converts per-channel PWM/direction pairs into H-bridge IN1/IN2 drives.
// A dead interval (both half-bridge inputs low) is inserted after reset,
// after enable rises, after a fault is cleared and on every direction
// change, so the bridge never sees a shoot-through or an abrupt reversal.
// A driver fault is synchronised, latched, and forces all bridges off
// until software clears it while the fault line is high again.
module abot_hbridge_ctrl #(
  parameter int NUM_CH       = 2,
  parameter int DEADTIME_CYC = 500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] pwm_in,
  input  logic [NUM_CH-1:0] dir_in,
  input  logic              fault_n,
  input  logic              fault_clr,
  output logic [NUM_CH-1:0] hb_in1,
  output logic [NUM_CH-1:0] hb_in2,
  output logic [NUM_CH-1:0] dead_active,
  output logic              fault_latched
);

  localparam int CNT_W = $clog2(DEADTIME_CYC + 1);
  // DEAD exits on the cycle it sees zero, so loading N-1 gives N dead cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEADTIME_CYC - 1);

  typedef enum logic [0:0] {
    ST_DEAD  = 1'b0,
    ST_DRIVE = 1'b1
  } ch_state_t;

  logic [NUM_CH-1:0] pwm_r;
  logic [NUM_CH-1:0] dir_r;
  logic              fault_meta_r;
  logic              fault_s;
  logic              fault_latched_r;
  logic              kill_s;

  // Register the PWM and direction inputs once.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_r <= {NUM_CH{1'b0}};
      dir_r <= {NUM_CH{1'b0}};
    end else begin
      pwm_r <= pwm_in;
      dir_r <= dir_in;
    end
  end

  // Two-flop synchroniser for the asynchronous fault line (idle high).
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_meta_r <= 1'b1;
      fault_s      <= 1'b1;
    end else begin
      fault_meta_r <= fault_n;
      fault_s      <= fault_meta_r;
    end
  end

  // Sticky fault flag: an active fault always wins over a clear request.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_latched_r <= 1'b0;
    end else if (!fault_s) begin
      fault_latched_r <= 1'b1;
    end else if (fault_clr) begin
      fault_latched_r <= 1'b0;
    end else begin
      fault_latched_r <= fault_latched_r;
    end
  end

  // Shared shutdown condition; includes the raw synchronised fault so the
  // bridges turn off in the same cycle the latch is being set.
  always_comb begin
    kill_s = ~enable | fault_latched_r | ~fault_s;
  end

  assign fault_latched = fault_latched_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_t        state_r;
    ch_state_t        state_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dir_act_r;
    logic             dir_act_nxt;
    logic             in1_nxt;
    logic             in2_nxt;
    logic             in1_r;
    logic             in2_r;
    logic             dead_r;

    // Next-state and next-output logic for one channel.
    always_comb begin
      state_nxt   = state_r;
      cnt_nxt     = cnt_r;
      dir_act_nxt = dir_act_r;
      in1_nxt     = 1'b0;
      in2_nxt     = 1'b0;
      case (state_r)
        ST_DEAD: begin
          if (kill_s) begin
            cnt_nxt = CNT_LOAD;
          end else if (cnt_r == {CNT_W{1'b0}}) begin
            state_nxt   = ST_DRIVE;
            dir_act_nxt = dir_r[g];
          end else begin
            cnt_nxt = cnt_r - CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (kill_s || (dir_r[g] != dir_act_r)) begin
            // Outputs already forced low this cycle, before the new
            // direction could ever reach the bridge.
            state_nxt = ST_DEAD;
            cnt_nxt   = CNT_LOAD;
          end else begin
            in1_nxt = pwm_r[g] & ~dir_act_r;
            in2_nxt = pwm_r[g] &  dir_act_r;
          end
        end
        default: begin
          state_nxt = ST_DEAD;
          cnt_nxt   = CNT_LOAD;
        end
      endcase
    end

    // State, counter and registered bridge outputs for one channel.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_r   <= ST_DEAD;
        cnt_r     <= CNT_LOAD;
        dir_act_r <= 1'b0;
        in1_r     <= 1'b0;
        in2_r     <= 1'b0;
        dead_r    <= 1'b1;
      end else begin
        state_r   <= state_nxt;
        cnt_r     <= cnt_nxt;
        dir_act_r <= dir_act_nxt;
        in1_r     <= in1_nxt;
        in2_r     <= in2_nxt;
        dead_r    <= (state_nxt == ST_DEAD);
      end
    end

    assign hb_in1[g]      = in1_r;
    assign hb_in2[g]      = in2_r;
    assign dead_active[g] = dead_r;
  end

endmodule
